dot_i8_seq: RTL and testbench

// Sequencer that computes long signed int8 dot products by streaming k-element chunks

---
 rtl/dot_i8_seq.sv | 141 ++++++++++++++
 tb/tb_dot_i8_seq.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_i8_seq.sv
// Streams k-element signed chunks through one combinational dot product and
// accumulates the partial sums into a single job result with valid/ready handshakes.

module dot_i8 #(
    parameter int bit_width = 8,
    parameter int k         = 32,
    localparam int dp_width = 2 * bit_width + $clog2(k)
) (
    input  logic signed [bit_width-1:0] i_a [k],
    input  logic signed [bit_width-1:0] i_b [k],
    output logic signed [dp_width-1:0]  o_dp
);

    logic signed [dp_width-1:0]    sum;
    logic signed [2*bit_width-1:0] prod;

    // Products are sign-extended to the full sum width before adding.
    always_comb begin
        sum  = '0;
        prod = '0;
        for (int i = 0; i < k; i++) begin
            prod = i_a[i] * i_b[i];
            sum  = sum + {{(dp_width - 2 * bit_width){prod[2*bit_width-1]}}, prod};
        end
    end

    assign o_dp = sum;

endmodule

module dot_i8_seq #(
    parameter int bit_width  = 8,
    parameter int k          = 32,
    parameter int max_chunks = 16,
    localparam int dp_width  = 2 * bit_width + $clog2(k),
    localparam int acc_width = dp_width + $clog2(max_chunks),
    localparam int len_width = $clog2(max_chunks) + 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_start,
    input  logic [len_width-1:0]        i_len,
    output logic                        o_busy,
    output logic                        o_err,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic signed [bit_width-1:0] i_vec_a [k],
    input  logic signed [bit_width-1:0] i_vec_b [k],
    output logic                        o_dp_valid,
    input  logic                        i_dp_ready,
    output logic signed [acc_width-1:0] o_dp
);

    localparam logic [len_width-1:0] LEN_MAX = len_width'(max_chunks);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                       state_q, state_d;
    logic signed [acc_width-1:0]  acc_q, acc_d;
    logic [len_width-1:0]         count_q, count_d;
    logic [len_width-1:0]         len_q, len_d;
    logic                         err_q, err_d;
    logic signed [dp_width-1:0]   chunk_dp;
    logic signed [acc_width-1:0]  chunk_ext;

    dot_i8 #(
        .bit_width(bit_width),
        .k        (k)
    ) u_dot (
        .i_a (i_vec_a),
        .i_b (i_vec_b),
        .o_dp(chunk_dp)
    );

    assign chunk_ext = {{(acc_width - dp_width){chunk_dp[dp_width-1]}}, chunk_dp};

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        len_d   = len_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    if (i_len == '0 || i_len > LEN_MAX) begin
                        err_d = 1'b1;
                    end else begin
                        len_d   = i_len;
                        acc_d   = '0;
                        count_d = '0;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                // o_ready is high throughout RUN, so i_valid alone marks an accept.
                if (i_valid) begin
                    acc_d   = acc_q + chunk_ext;
                    count_d = count_q + 1'b1;
                    if (count_q == len_q - 1'b1) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (i_dp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            count_q <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            len_q   <= len_d;
            err_q   <= err_d;
        end
    end

    assign o_busy     = (state_q != S_IDLE);
    assign o_ready    = (state_q == S_RUN);
    assign o_dp_valid = (state_q == S_DONE);
    assign o_err      = err_q;
    assign o_dp       = acc_q;

endmodule

// File: tb/tb_dot_i8_seq.sv
// Directed and randomized checks of the chunked dot-product sequencer against
// hand-computed values and a plain integer accumulation model.

module tb_dot_i8_seq;

    logic              clk;
    logic              rst_n;
    logic              i_start;
    logic [4:0]        i_len;
    logic              o_busy;
    logic              o_err;
    logic              i_valid;
    logic              o_ready;
    logic signed [7:0] va [32];
    logic signed [7:0] vb [32];
    logic              o_dp_valid;
    logic              i_dp_ready;
    logic signed [24:0] o_dp;

    int tests_run;
    int tests_failed;

    dot_i8_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (i_start),
        .i_len     (i_len),
        .o_busy    (o_busy),
        .o_err     (o_err),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_vec_a   (va),
        .i_vec_b   (vb),
        .o_dp_valid(o_dp_valid),
        .i_dp_ready(i_dp_ready),
        .o_dp      (o_dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int a, input int b);
        for (int e = 0; e < 32; e++) begin
            va[e] = 8'(a);
            vb[e] = 8'(b);
        end
    endtask

    task automatic start_job(input int len);
        i_start = 1'b1;
        i_len   = 5'(len);
        tick();
        i_start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        tests_run++;
        if (o_busy !== 1'b0 || o_err !== 1'b0 || o_ready !== 1'b0 || o_dp_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_flags: busy=%b err=%b ready=%b dp_valid=%b expected all 0",
                     o_busy, o_err, o_ready, o_dp_valid);
        end
        tests_run++;
        if (o_dp !== 25'sd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_dp: got %0d expected 0", o_dp);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_chunk();
        fill(-128, -128);
        start_job(1);
        tests_run++;
        if (o_busy !== 1'b1 || o_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL single_run: busy=%b ready=%b expected 1 1", o_busy, o_ready);
        end
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        tests_run++;
        if (o_dp_valid !== 1'b1 || o_dp !== 25'sd524288) begin
            tests_failed++;
            $display("[TB] FAIL single_dp: valid=%b dp=%0d expected 1 524288", o_dp_valid, o_dp);
        end
        i_dp_ready = 1'b1;
        tick();
        i_dp_ready = 1'b0;
        tests_run++;
        if (o_dp_valid !== 1'b0 || o_busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL single_idle: valid=%b busy=%b expected 0 0", o_dp_valid, o_busy);
        end
    endtask

    task automatic test_long_stall();
        int accepts;
        accepts = 0;
        fill(-128, 127);
        start_job(16);
        for (int c = 0; c < 100 && !o_dp_valid; c++) begin
            i_valid = (c % 2 == 0);
            if (i_valid && o_ready) accepts++;
            tick();
        end
        i_valid = 1'b0;
        tests_run++;
        if (o_dp_valid !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL long_timeout: dp_valid=%b expected 1", o_dp_valid);
        end
        tests_run++;
        if (accepts != 16) begin
            tests_failed++;
            $display("[TB] FAIL long_accepts: got %0d expected 16", accepts);
        end
        tests_run++;
        if (o_dp !== -25'sd8323072) begin
            tests_failed++;
            $display("[TB] FAIL long_dp: got %0d expected -8323072", o_dp);
        end
        i_dp_ready = 1'b1;
        tick();
        i_dp_ready = 1'b0;
    endtask

    task automatic test_bad_len();
        int lens [2];
        lens[0] = 0;
        lens[1] = 17;
        for (int t = 0; t < 2; t++) begin
            start_job(lens[t]);
            tests_run++;
            if (o_err !== 1'b1 || o_busy !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL bad_len_err len=%0d: err=%b busy=%b expected 1 0",
                         lens[t], o_err, o_busy);
            end
            tick();
            tests_run++;
            if (o_err !== 1'b0 || o_busy !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL bad_len_pulse len=%0d: err=%b busy=%b expected 0 0",
                         lens[t], o_err, o_busy);
            end
        end
    endtask

    task automatic test_done_hold();
        fill(1, 2);
        start_job(1);
        i_valid = 1'b1;
        tick();
        fill(100, 100);
        for (int c = 0; c < 5; c++) begin
            tests_run++;
            if (o_dp_valid !== 1'b1 || o_ready !== 1'b0 || o_dp !== 25'sd64) begin
                tests_failed++;
                $display("[TB] FAIL done_hold cycle %0d: valid=%b ready=%b dp=%0d expected 1 0 64",
                         c, o_dp_valid, o_ready, o_dp);
            end
            tick();
        end
        i_valid    = 1'b0;
        i_dp_ready = 1'b1;
        tick();
        i_dp_ready = 1'b0;
        tests_run++;
        if (o_busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL done_release: busy=%b expected 0", o_busy);
        end
    endtask

    task automatic test_reset_mid_run();
        fill(1, 1);
        start_job(8);
        i_valid = 1'b1;
        for (int c = 0; c < 3; c++) tick();
        i_valid = 1'b0;
        rst_n   = 1'b0;
        tick();
        tests_run++;
        if (o_busy !== 1'b0 || o_err !== 1'b0 || o_ready !== 1'b0 || o_dp_valid !== 1'b0 ||
            o_dp !== 25'sd0) begin
            tests_failed++;
            $display("[TB] FAIL mid_reset: busy=%b err=%b ready=%b valid=%b dp=%0d expected all 0",
                     o_busy, o_err, o_ready, o_dp_valid, o_dp);
        end
        rst_n = 1'b1;
        tick();
        fill(3, -2);
        start_job(2);
        i_valid = 1'b1;
        tick();
        tick();
        i_valid = 1'b0;
        tests_run++;
        if (o_dp_valid !== 1'b1 || o_dp !== -25'sd384) begin
            tests_failed++;
            $display("[TB] FAIL after_reset_job: valid=%b dp=%0d expected 1 -384", o_dp_valid, o_dp);
        end
        i_dp_ready = 1'b1;
        tick();
        i_dp_ready = 1'b0;
    endtask

    task automatic test_random_jobs();
        int len;
        int model;
        int accepts;
        logic signed [24:0] exp_dp;
        for (int j = 0; j < 200; j++) begin
            len     = $urandom_range(16, 1);
            model   = 0;
            accepts = 0;
            start_job(len);
            for (int c = 0; c < 400 && !o_dp_valid; c++) begin
                for (int e = 0; e < 32; e++) begin
                    va[e] = 8'($urandom);
                    vb[e] = 8'($urandom);
                end
                i_valid = ($urandom_range(3, 0) != 0);
                if (i_valid && o_ready) begin
                    accepts++;
                    for (int e = 0; e < 32; e++) model += int'(va[e]) * int'(vb[e]);
                end
                tick();
            end
            i_valid = 1'b0;
            exp_dp  = 25'(model);
            tests_run++;
            if (o_dp_valid !== 1'b1 || accepts != len || o_dp !== exp_dp) begin
                tests_failed++;
                $display("[TB] FAIL random_job %0d: valid=%b accepts=%0d dp=%0d expected 1 %0d %0d",
                         j, o_dp_valid, accepts, o_dp, len, exp_dp);
            end
            while ($urandom_range(2, 0) != 0) tick();
            i_dp_ready = 1'b1;
            tick();
            i_dp_ready = 1'b0;
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        i_start      = 1'b0;
        i_len        = '0;
        i_valid      = 1'b0;
        i_dp_ready   = 1'b0;
        fill(0, 0);
        test_reset();
        test_single_chunk();
        test_long_stall();
        test_bad_len();
        test_done_hold();
        test_reset_mid_run();
        test_random_jobs();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
